// File: rtl/stage_wb_superscalar.sv
// rtl/stage_wb_superscalar.sv - multi-lane writeback stage with load wait, trap kill, rd arbitration and retire count
module stage_wb_superscalar #(
  parameter int LANES = 2,
  parameter int XLEN  = 32,
  parameter int RET_W = 64
) (
  input  logic                  clk,
  input  logic                  start,
  input  logic [LANES-1:0]      valid_m,
  input  logic [LANES*5-1:0]    rd_m,
  input  logic [LANES-1:0]      regwrite_m,
  input  logic [LANES-1:0]      is_load_m,
  input  logic [LANES*3-1:0]    funct3_m,
  input  logic [LANES*2-1:0]    addr_lo_m,
  input  logic [LANES*XLEN-1:0] result_m,
  input  logic [LANES-1:0]      trap_m,
  output logic                  ready_m,
  input  logic                  mem_rvalid,
  input  logic [XLEN-1:0]       mem_rdata,
  output logic [LANES-1:0]      regwrite_w,
  output logic [LANES*5-1:0]    rd_w,
  output logic [LANES*XLEN-1:0] result_w,
  output logic                  kill_w,
  output logic                  busy_w,
  output logic [RET_W-1:0]      retire_cnt
);
  localparam int CW = $clog2(LANES + 1);

  typedef enum logic [1:0] {S_EMPTY, S_WAIT_LOAD, S_COMMIT} state_t;
  state_t r_state, w_state_nxt;

  logic [LANES-1:0]      w_alive, w_wmask, w_ld_oh;
  logic                  w_has_trap, w_has_ld, w_accept;
  logic [CW-1:0]         w_alive_cnt;
  logic [2:0]            w_ld_f3;
  logic [1:0]            w_ld_lo;
  logic [XLEN-1:0]       w_fmt;
  logic [LANES*XLEN-1:0] w_res_commit;

  // Bundle held while its load is outstanding
  logic [LANES*5-1:0]    r_rd_s;
  logic [LANES*XLEN-1:0] r_res_s;
  logic [LANES-1:0]      r_wmask_s, r_ld_oh_s;
  logic                  r_kill_s;
  logic [CW-1:0]         r_cnt_s;
  logic [2:0]            r_f3_s;
  logic [1:0]            r_lo_s;

  // Values presented during COMMIT; rd/result keep them afterwards
  logic [LANES*5-1:0]    r_rd_w;
  logic [LANES*XLEN-1:0] r_result_w;
  logic [LANES-1:0]      r_wmask_w;
  logic                  r_kill_w;
  logic [RET_W-1:0]      r_retire;

  assign w_accept = ready_m & (|valid_m);

  // Trap prefix kill, surviving-lane count and oldest surviving load lane
  always_comb begin : p_decode
    logic w_trap_seen;
    logic w_ld_seen;
    w_trap_seen = 1'b0;
    w_ld_seen   = 1'b0;
    w_alive     = '0;
    w_ld_oh     = '0;
    w_alive_cnt = '0;
    w_ld_f3     = 3'b010;
    w_ld_lo     = 2'b00;
    for (int i = 0; i < LANES; i++) begin
      w_trap_seen = w_trap_seen | (valid_m[i] & trap_m[i]);
      w_alive[i]  = valid_m[i] & ~w_trap_seen;
      if (w_alive[i] && is_load_m[i] && regwrite_m[i] && !w_ld_seen) begin
        w_ld_oh[i] = 1'b1;
        w_ld_seen  = 1'b1;
        w_ld_f3    = funct3_m[3*i +: 3];
        w_ld_lo    = addr_lo_m[2*i +: 2];
      end
      w_alive_cnt = w_alive_cnt + CW'(w_alive[i]);
    end
    w_has_trap = w_trap_seen;
    w_has_ld   = w_ld_seen;
  end

  // A surviving write is dropped when a younger survivor targets the same rd
  always_comb begin : p_wmask
    w_wmask = '0;
    for (int i = 0; i < LANES; i++) begin
      w_wmask[i] = w_alive[i] & regwrite_m[i] & (rd_m[5*i +: 5] != 5'd0);
      for (int j = i + 1; j < LANES; j++) begin
        if (w_alive[j] && regwrite_m[j] && (rd_m[5*j +: 5] == rd_m[5*i +: 5])) begin
          w_wmask[i] = 1'b0;
        end
      end
    end
  end

  // Align and extend the returned word for the staged load lane
  always_comb begin : p_format
    logic [7:0]  w_b;
    logic [15:0] w_h;
    w_b = mem_rdata[{r_lo_s, 3'b000} +: 8];
    w_h = mem_rdata[{r_lo_s[1], 4'b0000} +: 16];
    case (r_f3_s)
      3'b000:  w_fmt = {{(XLEN-8){w_b[7]}}, w_b};
      3'b001:  w_fmt = {{(XLEN-16){w_h[15]}}, w_h};
      3'b100:  w_fmt = {{(XLEN-8){1'b0}}, w_b};
      3'b101:  w_fmt = {{(XLEN-16){1'b0}}, w_h};
      default: w_fmt = mem_rdata;
    endcase
  end

  // Splice the formatted load data into the staged bundle
  always_comb begin
    w_res_commit = r_res_s;
    for (int i = 0; i < LANES; i++) begin
      if (r_ld_oh_s[i]) begin
        w_res_commit[XLEN*i +: XLEN] = w_fmt;
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge start) begin
    if (!start) r_state <= S_EMPTY;
    else        r_state <= w_state_nxt;
  end

  // Next-state: accept in EMPTY/COMMIT, leave WAIT_LOAD on load data
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_WAIT_LOAD: if (mem_rvalid) w_state_nxt = S_COMMIT;
      default: begin
        if (w_accept) w_state_nxt = w_has_ld ? S_WAIT_LOAD : S_COMMIT;
        else          w_state_nxt = S_EMPTY;
      end
    endcase
  end

  // Outputs decoded from the registered state
  always_comb begin
    ready_m    = (r_state != S_WAIT_LOAD);
    busy_w     = (r_state == S_WAIT_LOAD);
    regwrite_w = (r_state == S_COMMIT) ? r_wmask_w : '0;
    kill_w     = (r_state == S_COMMIT) & r_kill_w;
  end

  // Stage every accepted bundle; only load bundles read it back
  always_ff @(posedge clk or negedge start) begin
    if (!start) begin
      r_rd_s    <= '0;
      r_res_s   <= '0;
      r_wmask_s <= '0;
      r_ld_oh_s <= '0;
      r_kill_s  <= 1'b0;
      r_cnt_s   <= '0;
      r_f3_s    <= 3'b010;
      r_lo_s    <= 2'b00;
    end else if (w_accept) begin
      r_rd_s    <= rd_m;
      r_res_s   <= result_m;
      r_wmask_s <= w_wmask;
      r_ld_oh_s <= w_ld_oh;
      r_kill_s  <= w_has_trap;
      r_cnt_s   <= w_alive_cnt;
      r_f3_s    <= w_ld_f3;
      r_lo_s    <= w_ld_lo;
    end
  end

  // Load commit registers on entry to COMMIT; retire count is visible during COMMIT
  always_ff @(posedge clk or negedge start) begin
    if (!start) begin
      r_rd_w     <= '0;
      r_result_w <= '0;
      r_wmask_w  <= '0;
      r_kill_w   <= 1'b0;
      r_retire   <= '0;
    end else if (w_accept && !w_has_ld) begin
      r_rd_w     <= rd_m;
      r_result_w <= result_m;
      r_wmask_w  <= w_wmask;
      r_kill_w   <= w_has_trap;
      r_retire   <= r_retire + RET_W'(w_alive_cnt);
    end else if ((r_state == S_WAIT_LOAD) && mem_rvalid) begin
      r_rd_w     <= r_rd_s;
      r_result_w <= w_res_commit;
      r_wmask_w  <= r_wmask_s;
      r_kill_w   <= r_kill_s;
      r_retire   <= r_retire + RET_W'(r_cnt_s);
    end
  end

  assign rd_w       = r_rd_w;
  assign result_w   = r_result_w;
  assign retire_cnt = r_retire;
endmodule
